ledscandec: RTL and testbench
=============================

Name: ledscandec

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment encoder.
- Samples a multiplexed 7-segment display bus: one-hot digit select plus 8-bit segment pattern, bit7=a … bit1=g, bit0=dp.
- Debounces each digit over consecutive scans, decodes patterns back to 4-bit values, and presents a complete multi-digit frame on a valid/ready output.
- Used in self-checking display paths and as a display-snooping front end.

Parameters:
- DIGITS, 4, number of multiplexed digits.
- STABLE, 3, consecutive identical samples of a digit required to commit it (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_vld  in  1  sample strobe; led/dig sampled on clk edges where high.
- dig  in  DIGITS  one-hot digit select; bit i = digit i.
- led  in  8  segment pattern, a..g,dp in bits 7..0.
- out_bin  out  4*DIGITS  decoded frame; digit i in bits [4i+3:4i].
- out_dp  out  DIGITS  decimal-point bit per digit.
- out_err  out  DIGITS  1 = digit pattern unrecognised.
- out_vld  out  1  frame valid.
- out_rdy  in  1  consumer accepts frame.
- overrun  out  1  sticky: a frame was dropped while output was stalled.

Behaviour:
- Reset is asynchronous, active-low, one clock. While rst_n=0, every register clears: out_bin, out_dp, out_err, out_vld, overrun, per-digit candidate, count, committed value and seen flags, and dirty.
- Sample acceptance:
  - A sample occurs on an edge with seg_vld=1 and dig exactly one-hot.
  - dig=0 or more than one bit set: sample ignored, no state change.
- Decode uses led[7:1]; led[0] goes to dp.
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000001 (g only, dash) → 4'hF, err=0.
  - Any other pattern → 4'hE, err=1.
- Per-digit debounce, on a sample for digit i:
  - Full 8-bit led equal to cand[i]: cnt[i] increments, saturating at STABLE.
  - Otherwise: cand[i]=led, cnt[i]=1.
  - Commit on the edge where cnt[i] becomes STABLE (the first sample when STABLE=1): committed[i] = decode(cand), seen[i]=1.
  - A commit whose {bin,dp,err} differs from the last presented value of digit i, or any commit before the first frame, sets dirty.
- Frame output:
  - On an edge where all seen=1, dirty=1 and out_vld=0: load out_bin/out_dp/out_err from the committed registers, out_vld=1, dirty=0.
  - out_vld rises exactly one clock after the commit edge that made the frame complete or dirty.
  - While out_vld=1, outputs are held constant.
  - out_vld && out_rdy at an edge: out_vld=0 at that edge. A pending dirty frame loads on the following edge, so there is at least one idle cycle between frames.
  - A change-producing commit while out_vld=1 and dirty already 1 sets overrun. overrun clears only on reset.
  - Latest committed values win; intermediate frames are not queued.
- Simultaneous events:
  - A commit and a load on the same edge: the load uses the pre-commit committed values. The new commit re-sets dirty if it differs from the loaded frame.
- Reset mid-scan discards all partial counts; a full STABLE rounds of scanning is required before the next frame.

Test Plan:
- Reset → out_bin=0, out_dp=0, out_err=0, out_vld=0, overrun=0. Run 10 cycles with seg_vld=0 → out_vld stays 0.
- Scan digits 0..3 with patterns 01100000, 11011010, 11110010, 01100110, out_rdy=1, three full rounds → out_vld pulses for 1 cycle, starting one cycle after the digit-3 third sample. out_bin=16'h4321, out_dp=0, out_err=0.
- Same scan, but one sample of digit 1 replaced by 11111110 mid-round → digit-1 count restarts; frame appears only after three further consecutive 11011010 samples. No 8 ever presented.
- Digit 0 = 00000010, digit 1 = 10000000, digit 2 = 11111101 (0 with dp), digit 3 = 11110110 → out_bin=16'h90EF, out_err=4'b0010, out_dp=4'b0100.
- Hold out_rdy=0 after the first frame 4321, then commit two successive different frames (5555, then 6666) → outputs stay 4321, overrun=1. Raise out_rdy → out_vld drops, then after one idle cycle re-asserts with out_bin=16'h6666.
- Assert rst_n=0 mid-round after two rounds, then release. Also drive samples with dig=4'b0011 and dig=0 → no frame until three clean rounds complete; the invalid dig samples are ignored.

Source files
------------

// File: rtl/ledscandec.sv
// ledscandec: receive side of a multiplexed 7-segment display bus.
// Debounces each digit over consecutive scans, maps segment patterns back to
// 4-bit values and hands out whole frames on a valid/ready interface.
module ledscandec #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seg_vld,
    input  logic [DIGITS-1:0]     dig,
    input  logic [7:0]            led,
    output logic [4*DIGITS-1:0]   out_bin,
    output logic [DIGITS-1:0]     out_dp,
    output logic [DIGITS-1:0]     out_err,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  overrun
);

    localparam logic [3:0] STB = 4'(STABLE);

    // Returns {err, bin} for the a..g part of a segment pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b0000001: r = 5'h0F;
            default:    r = 5'h1E;
        endcase
        return r;
    endfunction

    logic [7:0]        cand [DIGITS];
    logic [3:0]        cnt  [DIGITS];
    logic [3:0]        cbin [DIGITS];
    logic [DIGITS-1:0] cdp;
    logic [DIGITS-1:0] cerr;
    logic [DIGITS-1:0] seen;
    logic              dirty;
    logic              presented;

    logic              smp;
    logic              load;
    logic [4:0]        dec;
    logic [DIGITS-1:0] hit;
    logic [DIGITS-1:0] match;
    logic [DIGITS-1:0] commit;
    logic [DIGITS-1:0] chg;
    logic [3:0]        nxt_cnt [DIGITS];
    logic              any_chg;

    // Sample qualification, per-digit debounce next-state and change detection.
    // When a frame loads on the same edge as a commit, the commit is compared
    // against the frame being loaded (the pre-commit committed value).
    always_comb begin
        smp     = seg_vld && $onehot(dig);
        load    = (&seen) && dirty && !out_vld;
        dec     = decode(led[7:1]);
        any_chg = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            hit[i]   = smp && dig[i];
            match[i] = (led == cand[i]);
            if (match[i])
                nxt_cnt[i] = (cnt[i] == STB) ? cnt[i] : cnt[i] + 4'd1;
            else
                nxt_cnt[i] = 4'd1;
            commit[i] = hit[i] && (nxt_cnt[i] == STB) && (!match[i] || cnt[i] != STB);
            if (load)
                chg[i] = commit[i] &&
                         ({dec[3:0], led[0], dec[4]} != {cbin[i], cdp[i], cerr[i]});
            else
                chg[i] = commit[i] && (!presented ||
                         ({dec[3:0], led[0], dec[4]} != {out_bin[4*i +: 4], out_dp[i], out_err[i]}));
            any_chg = any_chg | chg[i];
        end
    end

    // Debounce state and committed per-digit values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                cand[i] <= '0;
                cnt[i]  <= '0;
                cbin[i] <= '0;
            end
            cdp  <= '0;
            cerr <= '0;
            seen <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (hit[i]) begin
                    cnt[i] <= nxt_cnt[i];
                    if (!match[i])
                        cand[i] <= led;
                end
                if (commit[i]) begin
                    cbin[i] <= dec[3:0];
                    cdp[i]  <= led[0];
                    cerr[i] <= dec[4];
                    seen[i] <= 1'b1;
                end
            end
        end
    end

    // Frame output handshake, dirty tracking and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bin   <= '0;
            out_dp    <= '0;
            out_err   <= '0;
            out_vld   <= 1'b0;
            overrun   <= 1'b0;
            dirty     <= 1'b0;
            presented <= 1'b0;
        end else begin
            if (load) begin
                for (int i = 0; i < DIGITS; i++)
                    out_bin[4*i +: 4] <= cbin[i];
                out_dp    <= cdp;
                out_err   <= cerr;
                out_vld   <= 1'b1;
                presented <= 1'b1;
                dirty     <= any_chg;
            end else begin
                if (out_vld && out_rdy)
                    out_vld <= 1'b0;
                dirty <= dirty | any_chg;
            end
            if (any_chg && out_vld && dirty)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ledscandec.sv
// Scoreboard bench for ledscandec: stimulus pushes expected frames, a monitor
// pops and compares whenever a new frame is presented.
module tb_ledscandec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seg_vld = 1'b0;
    logic [3:0]  dig = '0;
    logic [7:0]  led = '0;
    logic [15:0] out_bin;
    logic [3:0]  out_dp;
    logic [3:0]  out_err;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic        overrun;

    typedef struct packed {
        logic [15:0] bin;
        logic [3:0]  dp;
        logic [3:0]  err;
    } frame_t;

    frame_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_cyc = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    int hi_cnt = 0;
    logic prev_vld = 1'b0;

    localparam logic [7:0] P1 = 8'b01100000;
    localparam logic [7:0] P2 = 8'b11011010;
    localparam logic [7:0] P3 = 8'b11110010;
    localparam logic [7:0] P4 = 8'b01100110;
    localparam logic [7:0] P5 = 8'b10110110;
    localparam logic [7:0] P6 = 8'b10111110;
    localparam logic [7:0] P8 = 8'b11111110;

    ledscandec #(.DIGITS(4), .STABLE(3)) dut (
        .clk(clk), .rst_n(rst_n), .seg_vld(seg_vld), .dig(dig), .led(led),
        .out_bin(out_bin), .out_dp(out_dp), .out_err(out_err),
        .out_vld(out_vld), .out_rdy(out_rdy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every newly presented frame against the scoreboard.
    always @(negedge clk) begin
        if (out_vld) hi_cnt++;
        if (out_vld && !prev_vld) begin
            rise_cnt++;
            rise_cyc = cyc;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h expected=none", out_bin);
            end else begin
                frame_t e;
                e = q.pop_front();
                chk("sb_bin", 32'(out_bin), 32'(e.bin));
                chk("sb_dp",  32'(out_dp),  32'(e.dp));
                chk("sb_err", 32'(out_err), 32'(e.err));
            end
        end
        prev_vld = out_vld;
    end

    task automatic smp(input logic [3:0] d, input logic [7:0] l);
        @(negedge clk);
        seg_vld = 1'b1;
        dig = d;
        led = l;
        @(posedge clk);
        #1 last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        seg_vld = 1'b0;
        dig = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic round(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        smp(4'b0001, a);
        smp(4'b0010, b);
        smp(4'b0100, c);
        smp(4'b1000, d);
    endtask

    task automatic do_reset();
        chk("sb_drain", 32'(q.size()), 32'd0);
        @(negedge clk);
        seg_vld = 1'b0;
        dig = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r0, h0, t;
        // Reset state and quiet bus
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_bin", 32'(out_bin), 32'd0);
        chk("rst_dp", 32'(out_dp), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        idle(10);
        chk("idle_no_frame", 32'(rise_cnt), 32'd0);

        // Basic 4321 frame, one-cycle pulse with out_rdy=1
        h0 = hi_cnt;
        q.push_back('{bin: 16'h4321, dp: 4'h0, err: 4'h0});
        round(P1, P2, P3, P4);
        round(P1, P2, P3, P4);
        round(P1, P2, P3, P4);
        t = last_cyc;
        idle(4);
        chk("basic_rise_cnt", 32'(rise_cnt), 32'd1);
        chk("basic_latency", 32'(rise_cyc), 32'(t + 1));
        chk("basic_pulse", 32'(hi_cnt - h0), 32'd1);

        // Glitch on digit 1 restarts its count
        do_reset();
        r0 = rise_cnt;
        q.push_back('{bin: 16'h4321, dp: 4'h0, err: 4'h0});
        round(P1, P2, P3, P4);
        round(P1, P8, P3, P4);
        round(P1, P2, P3, P4);
        round(P1, P2, P3, P4);
        chk("glitch_no_early", 32'(rise_cnt), 32'(r0));
        smp(4'b0001, P1);
        smp(4'b0010, P2);
        t = last_cyc;
        smp(4'b0100, P3);
        smp(4'b1000, P4);
        idle(4);
        chk("glitch_rise_cnt", 32'(rise_cnt), 32'(r0 + 1));
        chk("glitch_latency", 32'(rise_cyc), 32'(t + 1));

        // Dash, unrecognised pattern, decimal point, nine
        do_reset();
        r0 = rise_cnt;
        q.push_back('{bin: 16'h90EF, dp: 4'b0100, err: 4'b0010});
        repeat (3) round(8'b00000010, 8'b10000000, 8'b11111101, 8'b11110110);
        idle(4);
        chk("mixed_rise_cnt", 32'(rise_cnt), 32'(r0 + 1));

        // Stalled consumer: later frames collapse into the latest, overrun sets
        do_reset();
        out_rdy = 1'b0;
        q.push_back('{bin: 16'h4321, dp: 4'h0, err: 4'h0});
        repeat (3) round(P1, P2, P3, P4);
        repeat (3) round(P5, P5, P5, P5);
        repeat (3) round(P6, P6, P6, P6);
        idle(3);
        chk("stall_hold_vld", 32'(out_vld), 32'd1);
        chk("stall_hold_bin", 32'(out_bin), 32'h4321);
        chk("stall_overrun", 32'(overrun), 32'd1);
        q.push_back('{bin: 16'h6666, dp: 4'h0, err: 4'h0});
        out_rdy = 1'b1;
        @(posedge clk);
        #1 chk("stall_drop", 32'(out_vld), 32'd0);
        @(posedge clk);
        #1 chk("stall_reload_vld", 32'(out_vld), 32'd1);
        chk("stall_reload_bin", 32'(out_bin), 32'h6666);
        idle(3);
        chk("stall_overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-scan, plus invalid digit selects
        do_reset();
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        round(P1, P2, P3, P4);
        round(P1, P2, P3, P4);
        smp(4'b0001, P1);
        smp(4'b0010, P2);
        do_reset();
        r0 = rise_cnt;
        round(P1, P2, P3, P4);
        smp(4'b0011, P8);
        smp(4'b0000, P8);
        round(P1, P2, P3, P4);
        idle(3);
        chk("mid_rst_no_frame", 32'(rise_cnt), 32'(r0));
        q.push_back('{bin: 16'h4321, dp: 4'h0, err: 4'h0});
        round(P1, P2, P3, P4);
        idle(4);
        chk("mid_rst_frame", 32'(rise_cnt), 32'(r0 + 1));
        chk("sb_final_drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
